// File: rtl/bp_common_pkg.sv
// bp_common_pkg: cache-service message/packet types and the fill responder state encoding
package bp_common_pkg;

   localparam int paddr_width_gp = 40;
   localparam int dword_width_gp = 64;
   localparam int block_width_gp = 512;
   localparam int sets_gp        = 64;
   localparam int assoc_gp       = 8;
   localparam int index_gp       = $clog2(sets_gp);
   localparam int way_gp         = $clog2(assoc_gp);
   localparam int offset_gp      = $clog2(block_width_gp/8);
   localparam int ptag_gp        = paddr_width_gp - index_gp - offset_gp;

   typedef enum logic [2:0] {
      e_miss_load  = 3'd0,
      e_miss_store = 3'd1,
      e_uc_load    = 3'd2,
      e_uc_store   = 3'd3,
      e_wb         = 3'd4
   } bp_cache_req_msg_e;

   typedef enum logic [2:0] {
      e_COH_I = 3'd0,
      e_COH_S = 3'd1,
      e_COH_E = 3'd2,
      e_COH_F = 3'd3,
      e_COH_M = 3'd6,
      e_COH_O = 3'd7
   } bp_coh_states_e;

   typedef enum logic [1:0] {
      e_cache_data_mem_read     = 2'd0,
      e_cache_data_mem_write    = 2'd1,
      e_cache_data_mem_uncached = 2'd2
   } bp_cache_data_mem_opcode_e;

   typedef enum logic [2:0] {
      e_cache_tag_mem_set_clear  = 3'd0,
      e_cache_tag_mem_set_tag    = 3'd1,
      e_cache_tag_mem_invalidate = 3'd2,
      e_cache_tag_mem_set_state  = 3'd3,
      e_cache_tag_mem_read       = 3'd4
   } bp_cache_tag_mem_opcode_e;

   typedef enum logic [1:0] {
      e_cache_stat_mem_set_clear   = 2'd0,
      e_cache_stat_mem_read        = 2'd1,
      e_cache_stat_mem_clear_dirty = 2'd2
   } bp_cache_stat_mem_opcode_e;

   typedef enum logic [2:0] {
      e_ready,
      e_send_cmd,
      e_collect,
      e_wr_data,
      e_wr_tag,
      e_wr_stat,
      e_done
   } bp_cache_fill_state_e;

   typedef struct packed {
      bp_cache_req_msg_e           msg_type;
      logic [paddr_width_gp-1:0]   addr;
   } bp_cache_req_s;

   typedef struct packed {
      logic [way_gp-1:0] way;
   } bp_cache_req_metadata_s;

   typedef struct packed {
      bp_cache_data_mem_opcode_e   opcode;
      logic [index_gp-1:0]         index;
      logic [way_gp-1:0]           way;
      logic [block_width_gp-1:0]   data;
   } bp_cache_data_mem_pkt_s;

   typedef struct packed {
      bp_cache_tag_mem_opcode_e    opcode;
      logic [index_gp-1:0]         index;
      logic [way_gp-1:0]           way;
      bp_coh_states_e              state;
      logic [ptag_gp-1:0]          tag;
   } bp_cache_tag_mem_pkt_s;

   typedef struct packed {
      bp_cache_stat_mem_opcode_e   opcode;
      logic [index_gp-1:0]         index;
      logic [way_gp-1:0]           way;
   } bp_cache_stat_mem_pkt_s;

   function automatic logic is_fill_msg(input bp_cache_req_msg_e m);
      return m == e_miss_load || m == e_miss_store;
   endfunction

endpackage

// File: rtl/bp_cache_fill_responder_sipo.sv
// bp_cache_fill_responder_sipo: assembles memory beats into a cache block, one dword slot per beat
module bp_cache_fill_responder_sipo #(
   parameter int els_p   = 8,
   parameter int width_p = 64
) (
   input  logic                       clk_i,
   input  logic                       v_i,
   input  logic [$clog2(els_p)-1:0]   slot_i,
   input  logic [width_p-1:0]         data_i,
   output logic [els_p*width_p-1:0]   data_o
);

   always_ff @(posedge clk_i)
      if (v_i) data_o[slot_i*width_p +: width_p] <= data_i;

endmodule

// File: rtl/bp_cache_fill_responder.sv
// bp_cache_fill_responder: services one cache miss at a time, fetching the block and writing data, tag and stat
module bp_cache_fill_responder
   import bp_common_pkg::*;
#(
   parameter int paddr_width_p = paddr_width_gp,
   parameter int dword_width_p = dword_width_gp,
   parameter int block_width_p = block_width_gp,
   parameter int sets_p        = sets_gp,
   parameter int assoc_p       = assoc_gp
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  bp_cache_req_s                 cache_req_i,
   input  logic                          cache_req_v_i,
   output logic                          cache_req_ready_o,
   input  bp_cache_req_metadata_s        cache_req_metadata_i,
   input  logic                          cache_req_metadata_v_i,
   output logic                          cache_req_complete_o,
   output bp_cache_data_mem_pkt_s        data_mem_pkt_o,
   output logic                          data_mem_pkt_v_o,
   input  logic                          data_mem_pkt_yumi_i,
   output bp_cache_tag_mem_pkt_s         tag_mem_pkt_o,
   output logic                          tag_mem_pkt_v_o,
   input  logic                          tag_mem_pkt_yumi_i,
   output bp_cache_stat_mem_pkt_s        stat_mem_pkt_o,
   output logic                          stat_mem_pkt_v_o,
   input  logic                          stat_mem_pkt_yumi_i,
   output logic [paddr_width_p-1:0]      mem_cmd_addr_o,
   output logic                          mem_cmd_v_o,
   input  logic                          mem_cmd_ready_i,
   input  logic [dword_width_p-1:0]      mem_resp_data_i,
   input  logic                          mem_resp_v_i,
   output logic                          mem_resp_yumi_o
);

   localparam int beats_lp  = block_width_p/dword_width_p;
   localparam int index_lp  = $clog2(sets_p);
   localparam int way_lp    = $clog2(assoc_p);
   localparam int offset_lp = $clog2(block_width_p/8);
   localparam int ptag_lp   = paddr_width_p - index_lp - offset_lp;
   localparam int cnt_lp    = $clog2(beats_lp) + 1;

   bp_cache_fill_state_e          state_r;
   logic [cnt_lp-1:0]             beat_cnt_r;
   logic                          way_v_r;
   logic [way_lp-1:0]             way_r;
   logic [paddr_width_p-1:0]      addr_r;
   bp_cache_req_msg_e             msg_r;
   logic [block_width_p-1:0]      block;
   logic [index_lp-1:0]           addr_index;
   logic                          accept, capture, last_beat;

   assign accept     = cache_req_ready_o & cache_req_v_i;
   // the victim way may arrive with the request or any time later, but never from before acceptance
   assign capture    = cache_req_metadata_v_i & ~way_v_r & (state_r == e_ready ? accept : state_r != e_done);
   assign last_beat  = beat_cnt_r == cnt_lp'(beats_lp - 1);
   assign addr_index = addr_r[offset_lp +: index_lp];

   assign cache_req_ready_o    = reset_n_i & (state_r == e_ready);
   assign mem_cmd_v_o          = (state_r == e_send_cmd) & is_fill_msg(msg_r);
   assign mem_cmd_addr_o       = addr_r;
   assign mem_resp_yumi_o      = (state_r == e_collect) & mem_resp_v_i;
   assign data_mem_pkt_v_o     = (state_r == e_wr_data) & way_v_r;
   assign tag_mem_pkt_v_o      = state_r == e_wr_tag;
   assign stat_mem_pkt_v_o     = state_r == e_wr_stat;
   assign cache_req_complete_o = state_r == e_done;

   assign data_mem_pkt_o = '{opcode: e_cache_data_mem_write, index: addr_index, way: way_r, data: block};
   assign tag_mem_pkt_o  = '{opcode: e_cache_tag_mem_set_tag, index: addr_index, way: way_r,
                             state: (msg_r == e_miss_store ? e_COH_M : e_COH_S),
                             tag: addr_r[paddr_width_p-1 -: ptag_lp]};
   assign stat_mem_pkt_o = '{opcode: e_cache_stat_mem_set_clear, index: addr_index, way: way_r};

   always_ff @(posedge clk_i or negedge reset_n_i)
      if (!reset_n_i) begin
         state_r    <= e_ready;
         beat_cnt_r <= '0;
         way_v_r    <= 1'b0;
      end else begin
         way_v_r <= state_r == e_done ? 1'b0 : way_v_r | capture;
         if (mem_resp_yumi_o) beat_cnt_r <= last_beat ? '0 : beat_cnt_r + 1'b1;
         case (state_r)
            e_ready:    if (cache_req_v_i) state_r <= e_send_cmd;
            e_send_cmd: if (!is_fill_msg(msg_r)) state_r <= e_done;
                        else if (mem_cmd_ready_i) state_r <= e_collect;
            e_collect:  if (mem_resp_v_i && last_beat) state_r <= e_wr_data;
            e_wr_data:  if (data_mem_pkt_yumi_i && data_mem_pkt_v_o) state_r <= e_wr_tag;
            e_wr_tag:   if (tag_mem_pkt_yumi_i && tag_mem_pkt_v_o) state_r <= e_wr_stat;
            e_wr_stat:  if (stat_mem_pkt_yumi_i && stat_mem_pkt_v_o) state_r <= e_done;
            e_done:     state_r <= e_ready;
            default:    state_r <= e_ready;
         endcase
      end

   always_ff @(posedge clk_i) begin
      if (state_r == e_ready && cache_req_v_i) begin
         addr_r <= {cache_req_i.addr[paddr_width_p-1:offset_lp], offset_lp'(0)};
         msg_r  <= cache_req_i.msg_type;
      end
      if (capture) way_r <= cache_req_metadata_i.way;
   end

   bp_cache_fill_responder_sipo #(
      .els_p   (beats_lp),
      .width_p (dword_width_p)
   ) sipo (
      .clk_i  (clk_i),
      .v_i    (mem_resp_yumi_o),
      .slot_i (beat_cnt_r[cnt_lp-2:0]),
      .data_i (mem_resp_data_i),
      .data_o (block)
   );

endmodule

// File: tb/tb_bp_cache_fill_responder.sv
// tb_bp_cache_fill_responder: directed fill vectors plus reset and uncached sequences
module tb_bp_cache_fill_responder;
   import bp_common_pkg::*;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   bp_cache_req_s            cache_req;
   logic                     cache_req_v, cache_req_ready;
   bp_cache_req_metadata_s   meta;
   logic                     meta_v, complete;
   bp_cache_data_mem_pkt_s   data_pkt;
   logic                     data_v, data_yumi;
   bp_cache_tag_mem_pkt_s    tag_pkt;
   logic                     tag_v, tag_yumi;
   bp_cache_stat_mem_pkt_s   stat_pkt;
   logic                     stat_v, stat_yumi;
   logic [39:0]              cmd_addr;
   logic                     cmd_v, cmd_ready;
   logic [63:0]              resp_data;
   logic                     resp_v, resp_yumi;
   int                       n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   bp_cache_fill_responder dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .cache_req_i(cache_req), .cache_req_v_i(cache_req_v), .cache_req_ready_o(cache_req_ready),
      .cache_req_metadata_i(meta), .cache_req_metadata_v_i(meta_v),
      .cache_req_complete_o(complete),
      .data_mem_pkt_o(data_pkt), .data_mem_pkt_v_o(data_v), .data_mem_pkt_yumi_i(data_yumi),
      .tag_mem_pkt_o(tag_pkt), .tag_mem_pkt_v_o(tag_v), .tag_mem_pkt_yumi_i(tag_yumi),
      .stat_mem_pkt_o(stat_pkt), .stat_mem_pkt_v_o(stat_v), .stat_mem_pkt_yumi_i(stat_yumi),
      .mem_cmd_addr_o(cmd_addr), .mem_cmd_v_o(cmd_v), .mem_cmd_ready_i(cmd_ready),
      .mem_resp_data_i(resp_data), .mem_resp_v_i(resp_v), .mem_resp_yumi_o(resp_yumi)
   );

   typedef struct {
      bp_cache_req_msg_e msg;
      logic [39:0]       addr;
      logic [2:0]        way;
      int                meta_dly;
      int                cmd_dly;
      logic [63:0]       seed;
      int                d_dly, t_dly, s_dly;
      logic [39:0]       exp_cmd;
      logic [5:0]        exp_idx;
      logic [27:0]       exp_tag;
      bp_coh_states_e    exp_st;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [599:0] act, input logic [599:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // holds one packet channel for dly cycles before yumi; the other channels get stray yumis that must be ignored
   task automatic hold(input int sel, input int dly, input logic [599:0] exp, input string nm);
      int good = 0;
      for (int k = 0; k <= dly; k++) begin
         logic v, others;
         logic [599:0] p;
         if (sel == 0) begin v = data_v; p = 600'(data_pkt); end
         else if (sel == 1) begin v = tag_v; p = 600'(tag_pkt); end
         else begin v = stat_v; p = 600'(stat_pkt); end
         others = (sel != 0 && data_v) || (sel != 1 && tag_v) || (sel != 2 && stat_v) || complete;
         if (v && p == exp && !others) good++;
         data_yumi = sel == 0 ? k == dly : 1'b1;
         tag_yumi  = sel == 1 ? k == dly : 1'b1;
         stat_yumi = sel == 2 ? k == dly : 1'b1;
         @(posedge clk); #1;
      end
      data_yumi = 1'b0;
      tag_yumi  = 1'b0;
      stat_yumi = 1'b0;
      chk(nm, good, dly + 1);
   endtask

   task automatic do_fill(input vec_t v, input string nm);
      logic [511:0] blk;
      int n;
      for (int i = 0; i < 8; i++) blk[i*64 +: 64] = v.seed * 64'(i + 1);
      n = 0;
      while (!cache_req_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk({nm, "_ready"}, cache_req_ready, 1);
      cache_req   = '{msg_type: v.msg, addr: v.addr};
      cache_req_v = 1'b1;
      meta.way    = v.way;
      meta_v      = v.meta_dly == 0;
      @(posedge clk); #1;
      cache_req_v = 1'b0;
      meta_v      = 1'b0;
      fork
         if (v.meta_dly > 0) begin
            repeat (v.meta_dly - 1) @(posedge clk);
            #1 meta_v = 1'b1;
            @(posedge clk); #1;
            meta_v = 1'b0;
         end
         begin
            n = 0;
            for (int k = 0; k <= v.cmd_dly; k++) begin
               if (cmd_v && cmd_addr == v.exp_cmd) n++;
               cmd_ready = k == v.cmd_dly;
               @(posedge clk); #1;
            end
            cmd_ready = 1'b0;
            chk({nm, "_cmd_hold"}, n, v.cmd_dly + 1);
            chk({nm, "_cmd_drop"}, cmd_v, 0);
            for (int i = 0; i < 8; i++) begin
               resp_v    = 1'b1;
               resp_data = v.seed * 64'(i + 1);
               #1 chk($sformatf("%s_yumi%0d", nm, i), resp_yumi, 1);
               @(posedge clk); #1;
            end
            resp_v = 1'b0;
            n = 0;
            while (!data_v && n < 40) begin @(posedge clk); #1; n++; end
            chk({nm, "_data_wait"}, data_v, 1);
            hold(0, v.d_dly, 600'(bp_cache_data_mem_pkt_s'{opcode: e_cache_data_mem_write,
                 index: v.exp_idx, way: v.way, data: blk}), {nm, "_data_pkt"});
            hold(1, v.t_dly, 600'(bp_cache_tag_mem_pkt_s'{opcode: e_cache_tag_mem_set_tag,
                 index: v.exp_idx, way: v.way, state: v.exp_st, tag: v.exp_tag}), {nm, "_tag_pkt"});
            hold(2, v.s_dly, 600'(bp_cache_stat_mem_pkt_s'{opcode: e_cache_stat_mem_set_clear,
                 index: v.exp_idx, way: v.way}), {nm, "_stat_pkt"});
            chk({nm, "_complete"}, complete, 1);
            @(posedge clk); #1;
            chk({nm, "_complete_drop"}, complete, 0);
         end
      join
   endtask

   initial begin
      logic bad;
      vecs[0] = '{e_miss_load, 40'h00_8000_1234, 3'd3, 0, 0, 64'h11, 0, 0, 0,
                  40'h00_8000_1200, 6'h08, 28'h0080001, e_COH_S};
      vecs[1] = '{e_miss_store, 40'h00_1234_5678, 3'd6, 0, 5, 64'h0101_0101_0101_0101, 0, 0, 0,
                  40'h00_1234_5640, 6'h19, 28'h0012345, e_COH_M};
      vecs[2] = '{e_miss_load, 40'hFF_FFFF_FFC0, 3'd7, 0, 0, 64'hDEAD_BEEF_0000_0001, 3, 2, 4,
                  40'hFF_FFFF_FFC0, 6'h3F, 28'hFFF_FFFF, e_COH_S};
      vecs[3] = '{e_miss_load, 40'h00_0000_0040, 3'd5, 12, 0, 64'h1000_0000_0000_0000, 0, 0, 0,
                  40'h00_0000_0040, 6'h01, 28'h0000000, e_COH_S};
      vecs[4] = '{e_miss_store, 40'h00_C0DE_0FFF, 3'd0, 2, 1, 64'h3, 1, 0, 1,
                  40'h00_C0DE_0FC0, 6'h3F, 28'h00C0DE0, e_COH_M};
      vecs[5] = '{e_miss_load, 40'h00_0000_0100, 3'd1, 3, 0, 64'h0F0F_0000_0000_0001, 1, 1, 1,
                  40'h00_0000_0100, 6'h04, 28'h0000000, e_COH_S};
      cache_req = '0; cache_req_v = 1'b0; meta = '0; meta_v = 1'b0;
      data_yumi = 1'b0; tag_yumi = 1'b0; stat_yumi = 1'b0;
      cmd_ready = 1'b0; resp_data = '0; resp_v = 1'b1;
      repeat (2) @(posedge clk);
      #1 chk("reset_outs", {cache_req_ready, cmd_v, resp_yumi, data_v, tag_v, stat_v, complete}, 0);
      resp_v  = 1'b0;
      reset_n = 1'b1;
      #1 chk("reset_release_ready", cache_req_ready, 1);
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) do_fill(vecs[i], $sformatf("v%0d", i));

      // partial fill interrupted by reset
      cache_req   = '{msg_type: e_miss_load, addr: 40'h100};
      cache_req_v = 1'b1;
      meta.way    = 3'd2;
      meta_v      = 1'b1;
      @(posedge clk); #1;
      cache_req_v = 1'b0;
      meta_v      = 1'b0;
      cmd_ready   = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         resp_v    = 1'b1;
         resp_data = 64'hBAD0 + 64'(i);
         @(posedge clk); #1;
      end
      reset_n = 1'b0;
      #1 chk("midfill_reset_outs", {cache_req_ready, cmd_v, resp_yumi, data_v, tag_v, stat_v, complete}, 0);
      @(posedge clk); #1;
      chk("midfill_reset_held", {cache_req_ready, resp_yumi}, 0);
      resp_v  = 1'b0;
      reset_n = 1'b1;
      #1 chk("midfill_release_ready", cache_req_ready, 1);
      do_fill(vecs[5], "post_reset");

      // uncached request completes without touching memory or the cache arrays
      @(posedge clk); #1;
      cache_req   = '{msg_type: e_uc_load, addr: 40'h2000};
      cache_req_v = 1'b1;
      resp_v      = 1'b1;
      @(posedge clk); #1;
      cache_req_v = 1'b0;
      bad = cmd_v | data_v | tag_v | stat_v | resp_yumi;
      chk("uc_c1_complete", complete, 0);
      @(posedge clk); #1;
      bad |= cmd_v | data_v | tag_v | stat_v | resp_yumi;
      chk("uc_c2_complete", complete, 1);
      @(posedge clk); #1;
      bad |= cmd_v | data_v | tag_v | stat_v | resp_yumi;
      chk("uc_c3_complete", complete, 0);
      chk("uc_c3_ready", cache_req_ready, 1);
      chk("uc_no_side_effects", bad, 0);
      resp_v = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_cache_fill_responder.md
BP_CACHE_FILL_RESPONDER -- requirements
Module: bp_cache_fill_responder

Interface
REQ-001 SHALL take parameters (name, default, meaning): paddr_width_p, 40, physical address bits; dword_width_p, 64, memory beat width; block_width_p, 512, cache block bits; sets_p, 64, cache sets; assoc_p, 8, ways.
REQ-002 SHALL derive localparams: beats_lp = block_width_p/dword_width_p; index_lp = log2(sets_p); way_lp = log2(assoc_p); offset_lp = log2(block_width_p/8); ptag_lp = paddr_width_p-index_lp-offset_lp.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; clk_i in 1: clock; reset_n_i in 1: async active-low reset.
REQ-004 cache_req_i in bp_cache_req_s: miss request (msg_type, addr); cache_req_v_i in 1; cache_req_ready_o out 1.
REQ-005 cache_req_metadata_i in bp_cache_req_metadata_s: victim way; cache_req_metadata_v_i in 1.
REQ-006 cache_req_complete_o out 1: fill done pulse.
REQ-007 data_mem_pkt_o out bp_cache_data_mem_pkt_s; data_mem_pkt_v_o out 1; data_mem_pkt_yumi_i in 1.
REQ-008 tag_mem_pkt_o out bp_cache_tag_mem_pkt_s; tag_mem_pkt_v_o out 1; tag_mem_pkt_yumi_i in 1.
REQ-009 stat_mem_pkt_o out bp_cache_stat_mem_pkt_s; stat_mem_pkt_v_o out 1; stat_mem_pkt_yumi_i in 1.
REQ-010 mem_cmd_addr_o out paddr_width_p: block-aligned read address; mem_cmd_v_o out 1; mem_cmd_ready_i in 1.
REQ-011 mem_resp_data_i in dword_width_p: fill beat; mem_resp_v_i in 1; mem_resp_yumi_o out 1.

Function
REQ-012 SHALL implement FSM e_ready, e_send_cmd, e_collect, e_wr_data, e_wr_tag, e_wr_stat, e_done; one miss outstanding.
REQ-013 e_ready: cache_req_ready_o=1; on cache_req_v_i latch addr with offset zeroed, go e_send_cmd next cycle; other states: ready=0.
REQ-014 Victim way SHALL be captured from cache_req_metadata_i on the first cycle metadata_v_i=1 at or after request acceptance (same cycle allowed); e_wr_data SHALL not be left until captured.
REQ-015 e_send_cmd: mem_cmd_v_o=1 with latched address; on mem_cmd_ready_i go e_collect.
REQ-016 e_collect: mem_resp_yumi_o = mem_resp_v_i; each beat written at dword slot beat_cnt (beat 0 -> bits dword_width_p-1:0); counter width log2(beats_lp)+1; after beat beats_lp-1 clear counter, go e_wr_data.
REQ-017 e_wr_data: data_mem_pkt_v_o=1, opcode e_cache_data_mem_write, index=addr index, way=victim, data=assembled block; on yumi go e_wr_tag.
REQ-018 e_wr_tag: tag_mem_pkt_v_o=1, opcode e_cache_tag_mem_set_tag, state e_COH_M for msg_type e_miss_store else e_COH_S, tag=addr ptag; on yumi go e_wr_stat.
REQ-019 e_wr_stat: stat_mem_pkt_v_o=1, opcode e_cache_stat_mem_set_clear, same index/way; on yumi go e_done.
REQ-020 e_done: cache_req_complete_o=1 exactly one cycle; next state e_ready.
REQ-021 Each *_v_o SHALL stay high with stable payload until its yumi; yumi without valid SHALL be ignored.
REQ-022 Unsupported msg_type (uncached, wb) SHALL be accepted and completed via e_done directly, no mem_cmd, no pkt writes.
REQ-023 mem_resp_v_i outside e_collect SHALL not be consumed (yumi=0).

Reset
REQ-024 reset_n_i low SHALL immediately force e_ready, beat counter 0, victim-captured flag 0, all valid/yumi/complete outputs 0, cache_req_ready_o 0 while asserted.
REQ-025 Reset mid-fill SHALL discard partial block; first cycle after deassertion SHALL show cache_req_ready_o=1.
REQ-026 Datapath registers (block buffer, addr) need no reset.

Structure
REQ-027 FSM state enum SHALL reside in bp_common_pkg; pkt/req structs from existing cache-service declare macros.
REQ-028 Block assembly SHALL use one sub-module, bsg_serial_in_parallel_out_full (els beats_lp, width dword_width_p), or an equivalent inline shift register.

Verification
REQ-029 Load miss addr 0x80001234, metadata way 3 same cycle, beats 0..7 = 0x11..0x88 -> mem_cmd addr 0x80001200, data pkt way 3 index 0x08 slot0=0x11, tag state S, one complete pulse.
REQ-030 Store miss with mem_cmd_ready low 5 cycles -> mem_cmd_v_o held stable 6 cycles; tag state M.
REQ-031 Backpressure: data yumi delayed 3, tag 2, stat 4 cycles -> payloads stable, order data->tag->stat->complete.
REQ-032 Metadata arrives 12 cycles after request, beats done earlier -> data pkt waits, carries late way.
REQ-033 Reset asserted after 4 of 8 beats -> outputs 0 immediately; next request fills fully, no stale beats.
REQ-034 Uncached request -> complete pulse 2 cycles after acceptance, no mem_cmd or pkt valids.
